// File: rtl/retire_trace_buffer.sv
// Retire-trace capture buffer: records {PC, write-back data} of retiring
// instructions after an arm (optionally gated by a PC trigger), then drains via valid/ready.
module retire_trace_buffer #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                       tr_clk,
  input  logic                       tr_rst,
  input  logic                       tr_i_ce,
  input  logic                       tr_i_arm,
  input  logic                       tr_i_stop,
  input  logic                       tr_i_trig_en,
  input  logic [PC_WIDTH-1:0]        tr_i_trig_pc,
  input  logic                       tr_i_valid,
  input  logic [PC_WIDTH-1:0]        tr_i_pc,
  input  logic [DWIDTH-1:0]          tr_i_wb_data,
  input  logic                       tr_i_rd_ready,
  output logic                       tr_o_rd_valid,
  output logic [PC_WIDTH-1:0]        tr_o_rd_pc,
  output logic [DWIDTH-1:0]          tr_o_rd_data,
  output logic [$clog2(DEPTH):0]     tr_o_count,
  output logic                       tr_o_overflow,
  output logic [1:0]                 tr_o_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;
  logic            pop;
  logic            full;

  logic [PC_WIDTH-1:0] mem_pc   [DEPTH];
  logic [DWIDTH-1:0]   mem_data [DEPTH];

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    pop      = 1'b0;
    if (tr_i_ce) begin
      if (tr_i_arm) begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        ovf_d    = 1'b0;
        state_d  = tr_i_trig_en ? S_ARMED : S_CAPTURE;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (tr_i_valid && (tr_i_pc == tr_i_trig_pc)) begin
              wr_en   = 1'b1;
              state_d = S_CAPTURE;
            end
            if (tr_i_stop) state_d = S_DONE;
          end
          S_CAPTURE: begin
            if (tr_i_valid && (!full || WRAP_MODE != 0)) wr_en = 1'b1;
            if (tr_i_stop) state_d = S_DONE;
          end
          S_DONE: begin
            if ((count_q != '0) && tr_i_rd_ready) pop = 1'b1;
          end
          default: ;
        endcase

        // A write into a full buffer (wrap mode only) evicts the oldest entry.
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (full) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            ovf_d    = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
          if (WRAP_MODE == 0 && count_q == CW'(DEPTH - 1)) state_d = S_DONE;
        end

        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tr_clk or negedge tr_rst) begin
    if (!tr_rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge tr_clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]   <= tr_i_pc;
      mem_data[wr_ptr_q] <= tr_i_wb_data;
    end
  end

  assign tr_o_rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign tr_o_rd_pc    = tr_o_rd_valid ? mem_pc[rd_ptr_q]   : '0;
  assign tr_o_rd_data  = tr_o_rd_valid ? mem_data[rd_ptr_q] : '0;
  assign tr_o_count    = count_q;
  assign tr_o_overflow = ovf_q;
  assign tr_o_state    = state_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a stop-mode and a wrap-mode instance
// (DEPTH = 4) share one stimulus stream.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, arm, stop, trig_en, valid, rd_ready;
  logic [31:0] trig_pc, pc, wb_data;

  logic        s_rd_valid, w_rd_valid;
  logic [31:0] s_rd_pc, w_rd_pc, s_rd_data, w_rd_data;
  logic [2:0]  s_count, w_count;
  logic        s_ovf, w_ovf;
  logic [1:0]  s_state, w_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.PC_WIDTH(32), .DWIDTH(32), .DEPTH(4), .WRAP_MODE(0)) u_stop (
    .tr_clk(clk), .tr_rst(rst_n), .tr_i_ce(ce), .tr_i_arm(arm), .tr_i_stop(stop),
    .tr_i_trig_en(trig_en), .tr_i_trig_pc(trig_pc), .tr_i_valid(valid), .tr_i_pc(pc),
    .tr_i_wb_data(wb_data), .tr_i_rd_ready(rd_ready), .tr_o_rd_valid(s_rd_valid),
    .tr_o_rd_pc(s_rd_pc), .tr_o_rd_data(s_rd_data), .tr_o_count(s_count),
    .tr_o_overflow(s_ovf), .tr_o_state(s_state)
  );

  retire_trace_buffer #(.PC_WIDTH(32), .DWIDTH(32), .DEPTH(4), .WRAP_MODE(1)) u_wrap (
    .tr_clk(clk), .tr_rst(rst_n), .tr_i_ce(ce), .tr_i_arm(arm), .tr_i_stop(stop),
    .tr_i_trig_en(trig_en), .tr_i_trig_pc(trig_pc), .tr_i_valid(valid), .tr_i_pc(pc),
    .tr_i_wb_data(wb_data), .tr_i_rd_ready(rd_ready), .tr_o_rd_valid(w_rd_valid),
    .tr_o_rd_pc(w_rd_pc), .tr_o_rd_data(w_rd_data), .tr_o_count(w_count),
    .tr_o_overflow(w_ovf), .tr_o_state(w_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; valid = 1'b0;
    rd_ready = 1'b0; trig_pc = '0; pc = '0; wb_data = '0;
    tick(); tick();
    chk("rst_s_state", 64'(s_state), 64'(0));
    chk("rst_w_state", 64'(w_state), 64'(0));
    chk("rst_s_count", 64'(s_count), 64'(0));
    chk("rst_s_rdv",   64'(s_rd_valid), 64'(0));
    chk("rst_s_rdpc",  64'(s_rd_pc), 64'(0));
    chk("rst_w_ovf",   64'(w_ovf), 64'(0));
    rst_n = 1'b1;

    // Scenarios 1 and 2: immediate capture, 6 retires
    arm = 1'b1; valid = 1'b1; pc = 32'h999; wb_data = 32'h999;
    tick();
    arm = 1'b0; valid = 1'b0;
    chk("arm_s_state", 64'(s_state), 64'(2));
    chk("arm_s_count", 64'(s_count), 64'(0));
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; pc = 32'(4 * i); wb_data = 32'(32'hA0 + i);
      tick();
      if (i == 3) begin
        chk("full_s_state", 64'(s_state), 64'(3));
        chk("full_s_count", 64'(s_count), 64'(4));
        chk("full_w_state", 64'(w_state), 64'(2));
        chk("full_w_ovf",   64'(w_ovf), 64'(0));
      end
    end
    valid = 1'b0;
    chk("t1_s_count", 64'(s_count), 64'(4));
    chk("t1_s_ovf",   64'(s_ovf), 64'(0));
    chk("t2_w_count", 64'(w_count), 64'(4));
    chk("t2_w_ovf",   64'(w_ovf), 64'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_w_state", 64'(w_state), 64'(3));
    chk("t1_s_state", 64'(s_state), 64'(3));
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t1_rdv",  64'(s_rd_valid), 64'(1));
      chk("t1_pc",   64'(s_rd_pc),   64'(4 * k));
      chk("t1_data", 64'(s_rd_data), 64'(32'hA0 + k));
      chk("t2_pc",   64'(w_rd_pc),   64'(8 + 4 * k));
      chk("t2_data", 64'(w_rd_data), 64'(32'hA2 + k));
      tick();
    end
    rd_ready = 1'b0;
    chk("t1_empty_rdv", 64'(s_rd_valid), 64'(0));
    chk("t1_empty_cnt", 64'(s_count), 64'(0));
    chk("t1_empty_pc",  64'(s_rd_pc), 64'(0));
    chk("t2_empty_rdv", 64'(w_rd_valid), 64'(0));
    chk("t2_empty_st",  64'(w_state), 64'(3));

    // Scenario 3: trigger on PC 0x10
    trig_en = 1'b1; trig_pc = 32'h10; arm = 1'b1;
    tick();
    arm = 1'b0; trig_en = 1'b0;
    chk("t3_armed", 64'(s_state), 64'(1));
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1; pc = 32'(4 * i); wb_data = 32'(32'hA0 + i);
      tick();
      if (i == 3) begin
        chk("t3_wait_st",  64'(w_state), 64'(1));
        chk("t3_wait_cnt", 64'(w_count), 64'(0));
      end
      if (i == 4) chk("t3_hit_st", 64'(s_state), 64'(2));
    end
    valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_s_count", 64'(s_count), 64'(4));
    chk("t3_s_state", 64'(s_state), 64'(3));
    chk("t3_s_pc",    64'(s_rd_pc), 64'(32'h10));
    chk("t3_s_data",  64'(s_rd_data), 64'(32'hA4));
    chk("t3_w_pc",    64'(w_rd_pc), 64'(32'h14));
    chk("t3_w_ovf",   64'(w_ovf), 64'(1));

    // Scenario 4: ce low freezes capture
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t4_ovf_clr", 64'(w_ovf), 64'(0));
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; pc = 32'(32'h100 + 4 * i); wb_data = 32'(32'hB0 + i);
      tick();
    end
    chk("t4_count2", 64'(s_count), 64'(2));
    ce = 1'b0; valid = 1'b1; pc = 32'h108; wb_data = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_frz_cnt", 64'(s_count), 64'(2));
      chk("t4_frz_st",  64'(s_state), 64'(2));
    end
    ce = 1'b1;
    tick();
    valid = 1'b0;
    chk("t4_resume", 64'(s_count), 64'(3));

    // Scenario 5: async reset mid-capture
    rst_n = 1'b0;
    #1;
    chk("t5_state", 64'(s_state), 64'(0));
    chk("t5_count", 64'(s_count), 64'(0));
    chk("t5_rdv",   64'(s_rd_valid), 64'(0));
    tick();
    rst_n = 1'b1;

    // Scenario 6: hold head while not ready, then drain
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; pc = 32'(32'h200 + 4 * i); wb_data = 32'(32'hC0 + i);
      tick();
    end
    valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_state", 64'(s_state), 64'(3));
    chk("t6_count", 64'(s_count), 64'(2));
    valid = 1'b1; pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_rdv", 64'(s_rd_valid), 64'(1));
      chk("t6_hold_pc",  64'(s_rd_pc), 64'(32'h200));
      chk("t6_hold_cnt", 64'(s_count), 64'(2));
    end
    valid = 1'b0; rd_ready = 1'b1;
    tick();
    chk("t6_pop1_pc",  64'(s_rd_pc), 64'(32'h204));
    chk("t6_pop1_dat", 64'(s_rd_data), 64'(32'hC1));
    chk("t6_pop1_cnt", 64'(s_count), 64'(1));
    tick();
    rd_ready = 1'b0;
    chk("t6_pop2_rdv", 64'(s_rd_valid), 64'(0));
    chk("t6_pop2_cnt", 64'(s_count), 64'(0));
    chk("t6_pop2_st",  64'(s_state), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
